fpu_ss_wb_arbiter: RTL and testbench



---
 rtl/fpu_ss_pkg.sv | 4 +
 rtl/fpu_ss_wb_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_fpu_ss_wb_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_ss_pkg.sv
// Shared parameters of the FPU subsystem.
package fpu_ss_pkg;
    localparam int unsigned X_ID_WIDTH = 4;
endpackage

// File: rtl/fpu_ss_wb_arbiter.sv
// Writeback/result arbiter: buffered memory results, FPnew and CSR completions onto one
// result channel and one FP register-file write port. Same-cycle memory bypass: FPU_SS_WB_BYPASS_EN.
module fpu_ss_wb_arbiter
    import fpu_ss_pkg::*;
#(
    parameter int unsigned MEM_FIFO_DEPTH = 2,
    parameter int unsigned FLEN           = 32,
    parameter bit          PULP_ZFINX     = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  x_mem_req_hs_i,
    output logic                  mem_credit_o,
    input  logic                  x_mem_result_valid_i,
    input  logic [X_ID_WIDTH-1:0] x_mem_result_id_i,
    input  logic [FLEN-1:0]       x_mem_result_rdata_i,
    input  logic [4:0]            x_mem_result_rd_i,
    input  logic                  x_mem_result_we_i,
    input  logic                  fpu_out_valid_i,
    output logic                  fpu_out_ready_o,
    input  logic [X_ID_WIDTH-1:0] fpu_out_id_i,
    input  logic [FLEN-1:0]       fpu_out_result_i,
    input  logic [4:0]            fpu_out_rd_i,
    input  logic                  fpu_out_rd_is_fp_i,
    input  logic [4:0]            fpu_out_status_i,
    input  logic                  csr_valid_i,
    output logic                  csr_ready_o,
    input  logic [X_ID_WIDTH-1:0] csr_id_i,
    input  logic [31:0]           csr_data_i,
    input  logic [4:0]            csr_rd_i,
    output logic                  x_result_valid_o,
    input  logic                  x_result_ready_i,
    output logic [X_ID_WIDTH-1:0] x_result_id_o,
    output logic [31:0]           x_result_data_o,
    output logic [4:0]            x_result_rd_o,
    output logic                  x_result_we_o,
    output logic                  fpr_we_o,
    output logic [4:0]            fpr_waddr_o,
    output logic [FLEN-1:0]       fpr_wdata_o,
    output logic                  fflags_valid_o,
    output logic [4:0]            fflags_o,
    output logic                  overflow_o
);

    localparam int unsigned      PTR_W    = (MEM_FIFO_DEPTH > 1) ? $clog2(MEM_FIFO_DEPTH) : 1;
    localparam int unsigned      CNT_W    = $clog2(MEM_FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MEM_FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MEM_FIFO_DEPTH);

    typedef enum logic {GRANT_FPU = 1'b0, GRANT_CSR = 1'b1} grant_e;

    logic [X_ID_WIDTH-1:0] fifo_id_r    [MEM_FIFO_DEPTH];
    logic [FLEN-1:0]       fifo_rdata_r [MEM_FIFO_DEPTH];
    logic [4:0]            fifo_rd_r    [MEM_FIFO_DEPTH];
    logic                  fifo_we_r    [MEM_FIFO_DEPTH];

    logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]      fill_r, credit_r;
    logic                  overflow_r;
    grant_e                last_grant_r;

    logic                  fifo_empty_s, fifo_full_s, bypass_cand_s;
    logic                  grant_mem_s, grant_fpu_s, grant_csr_s;
    logic                  mem_hs_s, pop_s, push_s, write_s, drop_s;
    logic                  fpu_hs_s, csr_hs_s;
    logic [X_ID_WIDTH-1:0] head_id_s;
    logic [FLEN-1:0]       head_rdata_s;
    logic [4:0]            head_rd_s;
    logic                  head_we_s;

    assign fifo_empty_s = (fill_r == CNT_W'(0));
    assign fifo_full_s  = (fill_r == FULL_CNT);

`ifdef FPU_SS_WB_BYPASS_EN
    assign bypass_cand_s = x_mem_result_valid_i & fifo_empty_s;
`else
    assign bypass_cand_s = 1'b0;
`endif

    assign grant_mem_s = ~fifo_empty_s | bypass_cand_s;
    assign mem_hs_s    = grant_mem_s & x_result_ready_i;
    assign pop_s       = mem_hs_s & ~fifo_empty_s;
    // A bypassed result that handshakes this cycle never occupies a slot.
    assign push_s      = x_mem_result_valid_i & ~(bypass_cand_s & mem_hs_s);
    assign write_s     = push_s & (~fifo_full_s | pop_s);
    assign drop_s      = push_s & fifo_full_s & ~pop_s;

    // Round-robin between FPnew and CSR whenever memory is not presenting.
    always_comb begin
        grant_fpu_s = 1'b0;
        grant_csr_s = 1'b0;
        if (grant_mem_s) begin
            grant_fpu_s = 1'b0;
            grant_csr_s = 1'b0;
        end else if (fpu_out_valid_i && csr_valid_i) begin
            grant_fpu_s = (last_grant_r == GRANT_CSR);
            grant_csr_s = (last_grant_r == GRANT_FPU);
        end else begin
            grant_fpu_s = fpu_out_valid_i;
            grant_csr_s = csr_valid_i;
        end
    end

    assign fpu_out_ready_o = x_result_ready_i & grant_fpu_s;
    assign csr_ready_o     = x_result_ready_i & grant_csr_s;
    assign fpu_hs_s        = fpu_out_valid_i & fpu_out_ready_o;
    assign csr_hs_s        = csr_valid_i & csr_ready_o;

    // Memory entry presented: buffered head, or the arriving result when the buffer is empty.
    always_comb begin
        head_id_s    = x_mem_result_id_i;
        head_rdata_s = x_mem_result_rdata_i;
        head_rd_s    = x_mem_result_rd_i;
        head_we_s    = x_mem_result_we_i;
        if (!fifo_empty_s) begin
            head_id_s    = fifo_id_r[rd_ptr_r];
            head_rdata_s = fifo_rdata_r[rd_ptr_r];
            head_rd_s    = fifo_rd_r[rd_ptr_r];
            head_we_s    = fifo_we_r[rd_ptr_r];
        end else begin
            head_id_s    = x_mem_result_id_i;
            head_rdata_s = x_mem_result_rdata_i;
            head_rd_s    = x_mem_result_rd_i;
            head_we_s    = x_mem_result_we_i;
        end
    end

    // Result channel and FP write-port payload of the granted source.
    always_comb begin
        x_result_id_o   = '0;
        x_result_data_o = 32'h0000_0000;
        x_result_rd_o   = 5'd0;
        x_result_we_o   = 1'b0;
        fpr_we_o        = 1'b0;
        fpr_waddr_o     = 5'd0;
        fpr_wdata_o     = '0;
        if (grant_mem_s) begin
            x_result_id_o   = head_id_s;
            x_result_data_o = head_rdata_s[31:0];
            x_result_rd_o   = head_rd_s;
            fpr_we_o        = mem_hs_s & head_we_s & !PULP_ZFINX;
            fpr_waddr_o     = head_rd_s;
            fpr_wdata_o     = head_rdata_s;
        end else if (grant_fpu_s) begin
            x_result_id_o   = fpu_out_id_i;
            x_result_data_o = fpu_out_result_i[31:0];
            x_result_rd_o   = fpu_out_rd_i;
            if (fpu_out_rd_is_fp_i && !PULP_ZFINX) begin
                fpr_we_o    = x_result_ready_i;
                fpr_waddr_o = fpu_out_rd_i;
                fpr_wdata_o = fpu_out_result_i;
            end else begin
                x_result_we_o = 1'b1;
            end
        end else if (grant_csr_s) begin
            x_result_id_o   = csr_id_i;
            x_result_data_o = csr_data_i;
            x_result_rd_o   = csr_rd_i;
            x_result_we_o   = 1'b1;
        end else begin
            x_result_we_o   = 1'b0;
        end
    end

    assign x_result_valid_o = grant_mem_s | fpu_out_valid_i | csr_valid_i;
    assign fflags_valid_o   = fpu_hs_s;
    assign fflags_o         = fpu_hs_s ? fpu_out_status_i : 5'd0;
    assign mem_credit_o     = (credit_r < FULL_CNT);
    assign overflow_o       = overflow_r;

    // Buffer storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk_i) begin
        if (write_s) begin
            fifo_id_r[wr_ptr_r]    <= x_mem_result_id_i;
            fifo_rdata_r[wr_ptr_r] <= x_mem_result_rdata_i;
            fifo_rd_r[wr_ptr_r]    <= x_mem_result_rd_i;
            fifo_we_r[wr_ptr_r]    <= x_mem_result_we_i;
        end
    end

    // Buffer pointers, occupancy and sticky overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fill_r     <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (write_s) begin
                wr_ptr_r <= (wr_ptr_r == LAST_PTR) ? PTR_W'(0) : wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? PTR_W'(0) : rd_ptr_r + PTR_W'(1);
            end
            case ({write_s, pop_s})
                2'b10:   fill_r <= fill_r + CNT_W'(1);
                2'b01:   fill_r <= fill_r - CNT_W'(1);
                default: fill_r <= fill_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Credits: outstanding requests plus buffered entries, saturating at both ends.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credit_r <= '0;
        end else begin
            case ({x_mem_req_hs_i, mem_hs_s})
                2'b10:   credit_r <= (credit_r == FULL_CNT) ? credit_r : credit_r + CNT_W'(1);
                2'b01:   credit_r <= (credit_r == CNT_W'(0)) ? credit_r : credit_r - CNT_W'(1);
                default: credit_r <= credit_r;
            endcase
        end
    end

    // Fairness state moves only on a completed FPnew or CSR handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_r <= GRANT_CSR;
        end else if (fpu_hs_s) begin
            last_grant_r <= GRANT_FPU;
        end else if (csr_hs_s) begin
            last_grant_r <= GRANT_CSR;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: tb/tb_fpu_ss_wb_arbiter.sv
// Bench for fpu_ss_wb_arbiter: queue-level reference model compared every cycle,
// plus directed vectors with literal expectations (DEPTH=2 main instance, DEPTH=1 for overflow).
module tb_fpu_ss_wb_arbiter;
    import fpu_ss_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned FLEN  = 32;
    localparam int unsigned IW    = X_ID_WIDTH;
`ifdef FPU_SS_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_hs, mem_valid, mem_we, fpu_valid, fpu_is_fp, csr_valid, ready;
    logic [IW-1:0] mem_id, fpu_id, csr_id;
    logic [31:0]   mem_rdata, fpu_result, csr_data;
    logic [4:0]    mem_rd, fpu_rd, fpu_status, csr_rd;
    logic          credit, fpu_ready, csr_ready, res_valid, res_we, fpr_we, ff_valid, ovf;
    logic [IW-1:0] res_id;
    logic [31:0]   res_data, fpr_wdata;
    logic [4:0]    res_rd, fpr_waddr, fflags;

    logic          o_req_hs, o_mem_valid, o_mem_we, o_fpu_valid, o_fpu_is_fp, o_csr_valid, o_ready;
    logic [IW-1:0] o_mem_id, o_fpu_id, o_csr_id;
    logic [31:0]   o_mem_rdata, o_fpu_result, o_csr_data;
    logic [4:0]    o_mem_rd, o_fpu_rd, o_fpu_status, o_csr_rd;
    logic          o_credit, o_fpu_ready, o_csr_ready, o_res_valid, o_res_we, o_fpr_we, o_ff_valid, o_ovf;
    logic [IW-1:0] o_res_id;
    logic [31:0]   o_res_data, o_fpr_wdata;
    logic [4:0]    o_res_rd, o_fpr_waddr, o_fflags;

    fpu_ss_wb_arbiter #(.MEM_FIFO_DEPTH(DEPTH), .FLEN(FLEN), .PULP_ZFINX(1'b0)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .x_mem_req_hs_i(req_hs), .mem_credit_o(credit),
        .x_mem_result_valid_i(mem_valid), .x_mem_result_id_i(mem_id),
        .x_mem_result_rdata_i(mem_rdata), .x_mem_result_rd_i(mem_rd), .x_mem_result_we_i(mem_we),
        .fpu_out_valid_i(fpu_valid), .fpu_out_ready_o(fpu_ready), .fpu_out_id_i(fpu_id),
        .fpu_out_result_i(fpu_result), .fpu_out_rd_i(fpu_rd), .fpu_out_rd_is_fp_i(fpu_is_fp),
        .fpu_out_status_i(fpu_status), .csr_valid_i(csr_valid), .csr_ready_o(csr_ready),
        .csr_id_i(csr_id), .csr_data_i(csr_data), .csr_rd_i(csr_rd),
        .x_result_valid_o(res_valid), .x_result_ready_i(ready), .x_result_id_o(res_id),
        .x_result_data_o(res_data), .x_result_rd_o(res_rd), .x_result_we_o(res_we),
        .fpr_we_o(fpr_we), .fpr_waddr_o(fpr_waddr), .fpr_wdata_o(fpr_wdata),
        .fflags_valid_o(ff_valid), .fflags_o(fflags), .overflow_o(ovf)
    );

    fpu_ss_wb_arbiter #(.MEM_FIFO_DEPTH(1), .FLEN(FLEN), .PULP_ZFINX(1'b0)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .x_mem_req_hs_i(o_req_hs), .mem_credit_o(o_credit),
        .x_mem_result_valid_i(o_mem_valid), .x_mem_result_id_i(o_mem_id),
        .x_mem_result_rdata_i(o_mem_rdata), .x_mem_result_rd_i(o_mem_rd), .x_mem_result_we_i(o_mem_we),
        .fpu_out_valid_i(o_fpu_valid), .fpu_out_ready_o(o_fpu_ready), .fpu_out_id_i(o_fpu_id),
        .fpu_out_result_i(o_fpu_result), .fpu_out_rd_i(o_fpu_rd), .fpu_out_rd_is_fp_i(o_fpu_is_fp),
        .fpu_out_status_i(o_fpu_status), .csr_valid_i(o_csr_valid), .csr_ready_o(o_csr_ready),
        .csr_id_i(o_csr_id), .csr_data_i(o_csr_data), .csr_rd_i(o_csr_rd),
        .x_result_valid_o(o_res_valid), .x_result_ready_i(o_ready), .x_result_id_o(o_res_id),
        .x_result_data_o(o_res_data), .x_result_rd_o(o_res_rd), .x_result_we_o(o_res_we),
        .fpr_we_o(o_fpr_we), .fpr_waddr_o(o_fpr_waddr), .fpr_wdata_o(o_fpr_wdata),
        .fflags_valid_o(o_ff_valid), .fflags_o(o_fflags), .overflow_o(o_ovf)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: memory results as a bounded queue, credits as a plain integer.
    typedef struct {
        logic [IW-1:0] id;
        logic [31:0]   data;
        logic [4:0]    rd;
        logic          we;
    } ment_t;

    ment_t mq[$];
    int    m_credit   = 0;
    bit    m_last_fpu = 1'b0;
    bit    m_ovf      = 1'b0;

    always @(negedge clk) begin
        ment_t head, tmp;
        int    src;            // 0 none, 1 memory, 2 FPnew, 3 CSR
        bit    byp, e_fprwe, e_we, mem_done;
        if (!rst_n) begin
            mq.delete();
            m_credit   = 0;
            m_last_fpu = 1'b0;
            m_ovf      = 1'b0;
        end
        byp = BYP && (mq.size() == 0) && mem_valid;
        if (mq.size() > 0) head = mq[0];
        else begin
            head.id = mem_id; head.data = mem_rdata; head.rd = mem_rd; head.we = mem_we;
        end
        if (mq.size() > 0 || byp)        src = 1;
        else if (fpu_valid && csr_valid) src = m_last_fpu ? 3 : 2;
        else if (fpu_valid)              src = 2;
        else if (csr_valid)              src = 3;
        else                             src = 0;

        check("m_valid", res_valid, src != 0);
        check("m_credit", credit, m_credit < DEPTH);
        check("m_overflow", ovf, m_ovf);
        check("m_fpu_ready", fpu_ready, (src == 2) && ready);
        check("m_csr_ready", csr_ready, (src == 3) && ready);
        e_fprwe = ready && (((src == 1) && head.we) || ((src == 2) && fpu_is_fp));
        check("m_fpr_we", fpr_we, e_fprwe);
        if (e_fprwe) begin
            check("m_fpr_waddr", fpr_waddr, (src == 1) ? head.rd : fpu_rd);
            check("m_fpr_wdata", fpr_wdata, (src == 1) ? head.data : fpu_result);
        end
        if (src != 0)
            check("m_id", res_id, (src == 1) ? head.id : ((src == 2) ? fpu_id : csr_id));
        e_we = (src == 3) || ((src == 2) && !fpu_is_fp);
        if (src != 0) check("m_we", res_we, e_we);
        if (e_we) begin
            check("m_data", res_data, (src == 3) ? csr_data : fpu_result);
            check("m_rd", res_rd, (src == 3) ? csr_rd : fpu_rd);
        end
        check("m_fflags_valid", ff_valid, (src == 2) && ready);
        if ((src == 2) && ready) check("m_fflags", fflags, fpu_status);

        if (rst_n) begin
            mem_done = (src == 1) && ready;
            if (mem_done && mq.size() > 0) tmp = mq.pop_front();
            if (mem_valid && !(byp && ready)) begin
                tmp.id = mem_id; tmp.data = mem_rdata; tmp.rd = mem_rd; tmp.we = mem_we;
                if (mq.size() >= DEPTH) m_ovf = 1'b1;
                else mq.push_back(tmp);
            end
            if (req_hs && !mem_done && m_credit < DEPTH) m_credit++;
            else if (!req_hs && mem_done && m_credit > 0) m_credit--;
            if ((src == 2) && ready) m_last_fpu = 1'b1;
            else if ((src == 3) && ready) m_last_fpu = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_hs = 1'b0; mem_valid = 1'b0; mem_we = 1'b0; mem_id = '0; mem_rdata = 32'h0; mem_rd = 5'd0;
        fpu_valid = 1'b0; fpu_is_fp = 1'b0; fpu_id = '0; fpu_result = 32'h0; fpu_rd = 5'd0;
        fpu_status = 5'd0; csr_valid = 1'b0; csr_id = '0; csr_data = 32'h0; csr_rd = 5'd0; ready = 1'b0;
    endtask

    task automatic mem_in(input logic [IW-1:0] id, input logic [4:0] rd, input logic we, input logic [31:0] d);
        mem_valid = 1'b1; mem_id = id; mem_rd = rd; mem_we = we; mem_rdata = d;
    endtask

    initial begin
        idle();
        o_req_hs = 1'b0; o_mem_valid = 1'b0; o_mem_we = 1'b0; o_mem_id = '0; o_mem_rdata = 32'h0;
        o_mem_rd = 5'd0; o_fpu_valid = 1'b0; o_fpu_is_fp = 1'b0; o_fpu_id = '0; o_fpu_result = 32'h0;
        o_fpu_rd = 5'd0; o_fpu_status = 5'd0; o_csr_valid = 1'b0; o_csr_id = '0; o_csr_data = 32'h0;
        o_csr_rd = 5'd0; o_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", res_valid, 1'b0);
        check("rst_credit", credit, 1'b1);
        check("rst_overflow", ovf, 1'b0);
        rst_n = 1'b1;

        // Credits with DEPTH=2
        tick(); req_hs = 1'b1;
        tick(); req_hs = 1'b1; #2 check("credit_one_out", credit, 1'b1);
        tick(); req_hs = 1'b0; #2 check("credit_exhausted", credit, 1'b0);
        tick(); mem_in(4'd3, 5'd5, 1'b1, 32'h4049_0FDB); #2 check("mem_arrive_valid", res_valid, BYP);
        tick(); mem_valid = 1'b0; #2 check("mem_buffered", res_valid, 1'b1);
        check("mem_buf_no_we", fpr_we, 1'b0);
        check("mem_buf_credit", credit, 1'b0);
        tick(); ready = 1'b1; #2 check("mem_hs_fpr_we", fpr_we, 1'b1);
        check("mem_hs_waddr", fpr_waddr, 5'd5);
        check("mem_hs_id", res_id, 4'd3);
        tick(); ready = 1'b0; #2 check("credit_returned", credit, 1'b1);
        check("mem_drained", res_valid, 1'b0);

        // Round-robin FPnew/CSR
        fpu_id = 4'd1; fpu_result = 32'h4000_0000; fpu_rd = 5'd7; fpu_is_fp = 1'b1; fpu_status = 5'h01;
        csr_id = 4'd2; csr_data = 32'h0000_0003; csr_rd = 5'd9;
        for (int k = 0; k < 4; k++) begin
            tick(); fpu_valid = 1'b1; csr_valid = 1'b1; ready = 1'b1;
            #2 check("rr_fpu_ready", fpu_ready, (k % 2) == 0);
            check("rr_csr_ready", csr_ready, (k % 2) == 1);
            check("rr_fflags_valid", ff_valid, (k % 2) == 0);
        end

        // Integer-destination FPnew result
        tick(); csr_valid = 1'b0; fpu_is_fp = 1'b0; fpu_result = 32'h3F80_0000; fpu_rd = 5'd10; fpu_id = 4'd4;
        #2 check("int_we", res_we, 1'b1);
        check("int_data", res_data, 32'h3F80_0000);
        check("int_rd", res_rd, 5'd10);
        check("int_no_fpr_we", fpr_we, 1'b0);

        // Memory preemption over a waiting FPnew result
        tick(); fpu_is_fp = 1'b1; fpu_rd = 5'd11; fpu_result = 32'h4040_0000; fpu_id = 4'd5; ready = 1'b0;
        mem_in(4'd6, 5'd3, 1'b1, 32'h4120_0000);
        tick(); mem_valid = 1'b0; ready = 1'b1;
        #2 check("pre_mem_wins", fpu_ready, 1'b0);
        check("pre_mem_waddr", fpr_waddr, 5'd3);
        check("pre_mem_id", res_id, 4'd6);
        tick(); #2 check("pre_fpu_next", fpu_ready, 1'b1);
        check("pre_fpu_waddr", fpr_waddr, 5'd11);
        tick(); fpu_valid = 1'b0; ready = 1'b0;

        // CSR alone
        tick(); csr_valid = 1'b1; csr_id = 4'd7; csr_data = 32'hDEAD_BEEF; csr_rd = 5'd12; ready = 1'b1;
        #2 check("csr_we", res_we, 1'b1);
        check("csr_data", res_data, 32'hDEAD_BEEF);
        check("csr_no_fflags", ff_valid, 1'b0);
        tick(); csr_valid = 1'b0; ready = 1'b0;

        // Full buffer with simultaneous push and pop, then FIFO order
        tick(); mem_in(4'd8, 5'd1, 1'b1, 32'h1111_1111);
        tick(); mem_in(4'd9, 5'd2, 1'b0, 32'h2222_2222);
        tick(); mem_in(4'd10, 5'd4, 1'b1, 32'h3333_3333); ready = 1'b1;
        #2 check("full_head_id", res_id, 4'd8);
        tick(); mem_valid = 1'b0; #2 check("full_no_ovf", ovf, 1'b0);
        check("order_id9", res_id, 4'd9);
        check("store_no_fpr_we", fpr_we, 1'b0);
        tick(); #2 check("order_id10", res_id, 4'd10);
        tick(); ready = 1'b0; #2 check("order_empty", res_valid, 1'b0);

        // Overflow on the main instance, then asynchronous reset mid-operation
        tick(); mem_in(4'd12, 5'd6, 1'b1, 32'h4444_4444);
        tick(); mem_in(4'd13, 5'd7, 1'b1, 32'h5555_5555);
        tick(); mem_in(4'd14, 5'd8, 1'b1, 32'h6666_6666);
        tick(); mem_valid = 1'b0; #2 check("main_ovf", ovf, 1'b1);
        check("main_ovf_head", res_id, 4'd12);
        tick(); #1 rst_n = 1'b0;
        #1 check("midrst_valid", res_valid, 1'b0);
        check("midrst_credit", credit, 1'b1);
        check("midrst_ovf", ovf, 1'b0);
        tick(); rst_n = 1'b1;
        tick(); #2 check("postrst_empty", res_valid, 1'b0);

        // Overflow with DEPTH=1
        tick(); o_mem_valid = 1'b1; o_mem_id = 4'd1; o_mem_rd = 5'd2; o_mem_we = 1'b1; o_mem_rdata = 32'hAAAA_0001;
        tick(); o_mem_id = 4'd2; o_mem_rd = 5'd3; o_mem_rdata = 32'hAAAA_0002;
        tick(); o_mem_valid = 1'b0; #2 check("d1_ovf", o_ovf, 1'b1);
        check("d1_valid", o_res_valid, 1'b1);
        check("d1_id", o_res_id, 4'd1);
        tick(); tick(); #2 check("d1_ovf_sticky", o_ovf, 1'b1);
        tick(); o_ready = 1'b1; #2 check("d1_fpr_we", o_fpr_we, 1'b1);
        check("d1_waddr", o_fpr_waddr, 5'd2);
        tick(); #2 check("d1_dropped", o_res_valid, 1'b0);
        check("d1_ovf_end", o_ovf, 1'b1);
        o_ready = 1'b0;

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
